// File: rtl/boot_ctrl.sv
// Boot/program-load controller: streams a program image into instruction memory,
// zero-fills the remainder, and holds the core in reset until the image is complete.
module boot_ctrl #(
    parameter int unsigned p_INST_NUM   = 1024,
    parameter int unsigned p_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    run_start,
    input  logic                    in_valid,
    input  logic [15:0]             in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    mem_we,
    output logic [p_ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]             mem_wdata,
    output logic                    core_rst,
    output logic                    busy,
    output logic                    done,
    output logic                    err_overflow,
    output logic [p_ADDR_WIDTH:0]   word_count,
    output logic [15:0]             checksum
);

    localparam int unsigned AW = p_ADDR_WIDTH;
    localparam int unsigned CW = p_ADDR_WIDTH + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(p_INST_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FILL  = 3'd2,
        S_DRAIN = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] wc_d;
    logic [15:0]   cs_d;
    logic          ovf_d;

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            word_count   <= '0;
            checksum     <= '0;
            err_overflow <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_count   <= wc_d;
            checksum     <= cs_d;
            err_overflow <= ovf_d;
        end
    end

    // Next-state, counter update and write-port decode
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wc_d      = word_count;
        cs_d      = checksum;
        ovf_d     = err_overflow;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = 16'h0000;

        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    wc_d    = '0;
                    cs_d    = 16'h0000;
                    ovf_d   = 1'b0;
                end else if (run_start && state_q == S_IDLE) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = in_data;
                    addr_d    = addr_q + AW'(1);
                    wc_d      = word_count + CW'(1);
                    cs_d      = checksum + in_data;
                    if (in_last) begin
                        state_d = (addr_q == LAST_ADDR) ? S_RUN : S_FILL;
                    end else if (addr_q == LAST_ADDR) begin
                        ovf_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_FILL: begin
                mem_we = 1'b1;
                addr_d = addr_q + AW'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Excess words are swallowed until the loader ends the image
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign core_rst = (state_q != S_RUN);
    assign done     = (state_q == S_RUN);
    assign busy     = (state_q == S_LOAD) || (state_q == S_FILL) || (state_q == S_DRAIN);

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Boot/program-load controller for the RiSC-16 single-cycle system. It accepts a program image as a valid/ready word stream and writes it into the instruction memory, zero-filling every unused location. The core is held in reset until the image is complete, then released. The block sits between an external loader (UART/JTAG bridge or testbench) and the instruction memory write port plus core reset.

## Interface
- p_INST_NUM, 1024: instruction memory depth in 16-bit words; must equal 2**p_ADDR_WIDTH
- p_ADDR_WIDTH, 10: instruction memory address width
- clk  in  1  global clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-low
- load_start  in  1  single-cycle request to begin a new image load
- run_start  in  1  single-cycle request to release the core without loading, using the preloaded image
- in_valid  in  1  stream word valid
- in_data  in  16  stream word, in address order from 0
- in_last  in  1  marks the final word of the image; qualified by in_valid
- in_ready  out  1  controller can accept a word
- mem_we  out  1  instruction memory write enable
- mem_addr  out  p_ADDR_WIDTH  write address
- mem_wdata  out  16  write data
- core_rst  out  1  active-high reset to the core; 1 whenever state is not RUN
- busy  out  1  state is LOAD, FILL or DRAIN
- done  out  1  state is RUN
- err_overflow  out  1  sticky; image exceeded p_INST_NUM words
- word_count  out  p_ADDR_WIDTH+1  words written by the current or last load
- checksum  out  16  mod-2^16 sum of words written by the current or last load

## Operation
- States:
  - IDLE (reset state)
  - LOAD
  - FILL
  - DRAIN
  - RUN
- Registered state: state, addr_cnt, word_count, checksum, err_overflow.
- Write port, in_ready, core_rst, busy and done are decoded combinationally from registered state and inputs.
- Accept condition: in_valid & in_ready.
- IDLE:
  - in_ready=0, core_rst=1.
  - load_start moves to LOAD, clearing addr_cnt, word_count, checksum and err_overflow.
  - run_start moves to RUN.
  - If both are asserted, load_start wins.
- LOAD:
  - in_ready=1.
  - On accept: mem_we=1, mem_addr=addr_cnt, mem_wdata=in_data, all in the same cycle. addr_cnt, word_count and checksum (+in_data, wrapping) update at the edge.
  - Accept with in_last and addr_cnt < p_INST_NUM-1: go to FILL.
  - Accept with in_last at addr_cnt = p_INST_NUM-1: go to RUN, skipping FILL.
  - Accept without in_last at addr_cnt = p_INST_NUM-1: word is written, word_count becomes p_INST_NUM, err_overflow is set, go to DRAIN.
- FILL:
  - in_ready=0, mem_we=1, mem_wdata=0, mem_addr=addr_cnt; addr_cnt increments every cycle.
  - Go to RUN after the cycle that writes p_INST_NUM-1.
  - word_count and checksum do not change.
- DRAIN:
  - in_ready=1, mem_we=0; accepted words are discarded and do not change word_count or checksum.
  - Accept with in_last: go to IDLE. The core stays in reset; err_overflow stays 1.
- RUN:
  - core_rst=0, in_ready=0, mem_we=0.
  - load_start moves to LOAD with the same clears as from IDLE; core_rst returns to 1 in that LOAD cycle.
  - run_start is ignored.
- load_start and run_start are ignored in LOAD, FILL and DRAIN.
- mem_we is never 1 outside LOAD and FILL. mem_addr is don't-care when mem_we=0.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, addr_cnt=0, word_count=0, checksum=0, err_overflow=0. Outputs immediately become in_ready=0, mem_we=0, core_rst=1, busy=0, done=0.
- Reset mid-LOAD or mid-FILL aborts the load. No further writes occur; memory contents are left partial.
- Zero-latency write: a word accepted in cycle t is written in cycle t.
- Last word accepted at address N-1 in cycle t (N < p_INST_NUM): FILL writes addresses N..p_INST_NUM-1 in cycles t+1..t+p_INST_NUM-N; RUN (core_rst=0) starts in cycle t+p_INST_NUM-N+1.
- in_valid low in LOAD: no write, no counter change, in_ready stays 1.
- Throughput: one word per cycle in LOAD.

## Test plan
- p_INST_NUM=8: reset, run_start → next cycle done=1, core_rst=0, no mem_we ever asserted.
- p_INST_NUM=8: load_start, then words 0x1111, 0x2222, 0x3333 (last) back-to-back → writes at addresses 0..2, zeros at 3..7 over 5 cycles, RUN one cycle later, word_count=3, checksum=0x6666.
- p_INST_NUM=8: 8 words with in_last on the 8th, random in_valid gaps → no FILL cycles, RUN the cycle after the 8th accept, word_count=8.
- p_INST_NUM=8: 10 words, in_last on the 10th → 8 writes, err_overflow=1, DRAIN accepts 2 words without writing, then IDLE with core_rst=1.
- In RUN, load_start → core_rst=1 next cycle, counters cleared. Load 0xFFFF, 0x0002 (last) → checksum=0x0001 (wrap).
- rst pulsed low in the middle of FILL → mem_we=0 and core_rst=1 immediately, state IDLE, word_count=0.
